// File: rtl/safety_island_boot_ctrl_if.sv
// ----------------------------------------------------------------------------
// safety_island_boot_ctrl_if : boot-control signal bundle (debug, preload, core)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface safety_island_boot_ctrl_if #(
  parameter int AddrWidth = 32
);
  logic                 bootmode_i;
  logic [AddrWidth-1:0] jtag_addr_i;
  logic                 jtag_addr_valid_i;
  logic                 jtag_fetch_en_i;
  logic                 preload_done_i;
  logic                 fetch_en_o;
  logic [AddrWidth-1:0] boot_addr_o;
  logic                 bootmode_o;
  logic                 boot_err_o;

  modport master (
    output bootmode_i, jtag_addr_i, jtag_addr_valid_i, jtag_fetch_en_i, preload_done_i,
    input  fetch_en_o, boot_addr_o, bootmode_o, boot_err_o
  );

  modport slave (
    input  bootmode_i, jtag_addr_i, jtag_addr_valid_i, jtag_fetch_en_i, preload_done_i,
    output fetch_en_o, boot_addr_o, bootmode_o, boot_err_o
  );
endinterface

`default_nettype wire

// File: rtl/safety_island_boot_ctrl.sv
// ----------------------------------------------------------------------------
// safety_island_boot_ctrl : settles, samples bootmode, then releases the core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module safety_island_boot_ctrl #(
  parameter int                   AddrWidth       = 32,
  parameter int                   SettleCycles    = 16,
  parameter int                   PreloadTimeout  = 1024,
  parameter logic [AddrWidth-1:0] DefaultBootAddr = AddrWidth'(32'h0000_0080)
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_i,
  safety_island_boot_ctrl_if.slave   bus
);

  typedef enum logic {
    BOOT_JTAG      = 1'b0,
    BOOT_PRELOADED = 1'b1
  } bootmode_e;

  typedef enum logic [2:0] {
    S_SETTLE       = 3'd0,
    S_WAIT_JTAG    = 3'd1,
    S_WAIT_PRELOAD = 3'd2,
    S_BOOT         = 3'd3,
    S_ERROR        = 3'd4
  } state_e;

  localparam int SC_W = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam int TO_W = (PreloadTimeout > 1) ? $clog2(PreloadTimeout) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SettleCycles - 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'((PreloadTimeout == 0) ? 0 : PreloadTimeout - 1);
  localparam logic [AddrWidth-1:0] ALIGN_MASK = ~AddrWidth'(3);

  state_e               state;
  state_e               state_next;
  logic [SC_W-1:0]      settle_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic                 bootmode;
  logic [AddrWidth-1:0] boot_addr;
  logic                 fetch_en;
  logic                 boot_err;
  logic                 settle_done;
  logic                 addr_we;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_SETTLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    settle_done = 1'b0;
    addr_we     = 1'b0;
    case (state)
      S_SETTLE: begin
        addr_we = bus.jtag_addr_valid_i;
        if (settle_cnt == SETTLE_LAST) begin
          settle_done = 1'b1;
          state_next  = (bootmode_e'(bus.bootmode_i) == BOOT_PRELOADED) ? S_WAIT_PRELOAD
                                                                         : S_WAIT_JTAG;
        end
      end
      S_WAIT_JTAG: begin
        addr_we = bus.jtag_addr_valid_i;
        if (bus.jtag_fetch_en_i) begin
          state_next = S_BOOT;
        end
      end
      S_WAIT_PRELOAD: begin
        addr_we = bus.jtag_addr_valid_i;
        // A preload completing on the last allowed cycle still boots.
        if (bus.preload_done_i) begin
          state_next = S_BOOT;
        end else if ((PreloadTimeout != 0) && (to_cnt == TO_LAST)) begin
          state_next = S_ERROR;
        end
      end
      S_BOOT:  state_next = S_BOOT;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_SETTLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      settle_cnt <= '0;
      to_cnt     <= '0;
      bootmode   <= 1'b0;
      boot_addr  <= DefaultBootAddr;
      fetch_en   <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      if ((state == S_SETTLE) && (settle_cnt != '1)) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      // Timeout count is held at zero outside WAIT_PRELOAD so entry starts fresh.
      if (state != S_WAIT_PRELOAD) begin
        to_cnt <= '0;
      end else if (to_cnt != '1) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (settle_done) begin
        bootmode <= bus.bootmode_i;
      end
      if (addr_we) begin
        boot_addr <= bus.jtag_addr_i & ALIGN_MASK;
      end
      fetch_en <= (state == S_BOOT);
      boot_err <= (state == S_ERROR);
    end
  end

  assign bus.fetch_en_o  = fetch_en;
  assign bus.boot_addr_o = boot_addr;
  assign bus.bootmode_o  = bootmode;
  assign bus.boot_err_o  = boot_err;

endmodule

`default_nettype wire

// File: doc/safety_island_boot_ctrl.md
SAFETY_ISLAND_BOOT_CTRL -- requirements
Module: safety_island_boot_ctrl

Interface
REQ-001 Parameter: AddrWidth, 32, width of boot address (power of two, >= 8).
REQ-002 Parameter: SettleCycles, 16, cycles after reset release before bootmode is sampled (>= 1).
REQ-003 Parameter: PreloadTimeout, 1024, max cycles to wait for preload_done_i; 0 disables the timeout.
REQ-004 Parameter: DefaultBootAddr, 32'h0000_0080, boot address used when none is supplied.
REQ-005 Port: clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 Port: rst_i  input  1  reset, asynchronous, active-high.
REQ-007 Port: bootmode_i  input  1  bootmode_e encoding: 0 = Jtag, 1 = Preloaded.
REQ-008 Port: jtag_addr_i  input  AddrWidth  boot address written via debug.
REQ-009 Port: jtag_addr_valid_i  input  1  one-cycle strobe qualifying jtag_addr_i.
REQ-010 Port: jtag_fetch_en_i  input  1  one-cycle strobe requesting core start (Jtag mode).
REQ-011 Port: preload_done_i  input  1  level; memory preload complete (Preloaded mode).
REQ-012 Port: fetch_en_o  output  1  core fetch enable.
REQ-013 Port: boot_addr_o  output  AddrWidth  core boot address.
REQ-014 Port: bootmode_o  output  1  latched bootmode.
REQ-015 Port: boot_err_o  output  1  sticky preload-timeout error.

Function
REQ-016 FSM states SETTLE, WAIT_JTAG, WAIT_PRELOAD, BOOT, ERROR; SETTLE entered on reset.
REQ-017 SETTLE: counter increments each cycle; on the cycle the counter equals SettleCycles-1, bootmode_i is latched into bootmode_o and the FSM moves to WAIT_JTAG (0) or WAIT_PRELOAD (1).
REQ-018 bootmode_i is sampled exactly once per reset; later changes are ignored.
REQ-019 jtag_addr_valid_i is honoured in every state except BOOT and ERROR; captured address has bits [1:0] forced to 0.
REQ-020 Captured address register holds DefaultBootAddr until first accepted jtag_addr_valid_i; last accepted write wins.
REQ-021 WAIT_JTAG: jtag_fetch_en_i moves FSM to BOOT next cycle; strobes during SETTLE are dropped.
REQ-022 jtag_addr_valid_i and jtag_fetch_en_i in the same cycle: the new address is used for that boot.
REQ-023 WAIT_PRELOAD: preload_done_i high moves FSM to BOOT next cycle; jtag_fetch_en_i ignored.
REQ-024 WAIT_PRELOAD timeout counter starts at 0 on entry; when PreloadTimeout != 0 and count reaches PreloadTimeout-1 without preload_done_i, FSM moves to ERROR.
REQ-025 preload_done_i on the same cycle the timeout expires: BOOT wins, no error.
REQ-026 BOOT: fetch_en_o = 1 registered (first high cycle is the cycle after the transition edge); boot_addr_o = captured address, frozen; terminal until reset.
REQ-027 ERROR: fetch_en_o = 0, boot_err_o = 1; terminal until reset.
REQ-028 fetch_en_o, boot_err_o are registered outputs, glitch-free; boot_addr_o is stable whenever fetch_en_o = 1.
REQ-029 Counters saturate; never wrap.

Reset
REQ-030 On rst_i asserted (asynchronously): state = SETTLE, counters = 0, fetch_en_o = 0, boot_err_o = 0, bootmode_o = 0, boot_addr_o = DefaultBootAddr.
REQ-031 Reset asserted mid-operation (including BOOT) drops fetch_en_o immediately, without a clock edge.
REQ-032 After release, full SETTLE sequence repeats and bootmode is resampled.

Verification
REQ-033 bootmode_i=1, preload_done_i high at cycle 40 after release -> bootmode_o=1 at cycle 16, fetch_en_o=1 from cycle 42, boot_addr_o=0x80.
REQ-034 bootmode_i=0, jtag_addr 0x1C00_0003 valid at cycle 20, fetch strobe at cycle 30 -> fetch_en_o=1 from cycle 32, boot_addr_o=0x1C00_0000.
REQ-035 bootmode_i=0, fetch strobe at cycle 5 (in SETTLE) -> ignored, fetch_en_o stays 0 until a later strobe.
REQ-036 PreloadTimeout=8, bootmode_i=1, preload_done_i never -> boot_err_o=1 after 8 cycles in WAIT_PRELOAD, fetch_en_o=0; preload_done_i on the final timeout cycle -> BOOT, boot_err_o=0.
REQ-037 bootmode_i toggled after sampling -> bootmode_o unchanged.
REQ-038 rst_i pulsed while fetch_en_o=1 -> fetch_en_o=0 asynchronously, boot_addr_o=0x80, SETTLE resumes and bootmode is resampled.
